// File: rtl/loadable_counter_param.sv
// loadable_counter_param: up/down counter with load, runtime modulus, step, wrap/saturate and overflow/underflow pulses
module loadable_counter_param #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             updown,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lim,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             ovf,
  output logic             unf
);
  logic [WIDTH:0] s, l, qw, sum;
  logic [WIDTH-1:0] nq;
  logic no, nu;
  // One extra bit keeps lim+1 and q+s exact at full range
  always_comb begin
    l = {1'b0, lim};
    qw = {1'b0, q};
    s = step > lim ? l : {1'b0, step};
    sum = qw + s;
    nq = q;
    no = 1'b0;
    nu = 1'b0;
    if (s != '0) begin
      if (updown) begin
        if (q > lim) begin
          nq = sat ? lim : '0;
          no = 1'b1;
        end else if (sum > l) begin
          nq = sat ? lim : WIDTH'(sum - l - (WIDTH+1)'(1));
          no = 1'b1;
        end else begin
          nq = WIDTH'(sum);
        end
      end else begin
        if (q > lim) begin
          nq = lim;
        end else if (s > qw) begin
          nq = sat ? '0 : WIDTH'(qw + l + (WIDTH+1)'(1) - s);
          nu = 1'b1;
        end else begin
          nq = WIDTH'(qw - s);
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (ld) begin
      q <= d > lim ? lim : d;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (en) begin
      q <= nq;
      ovf <= no;
      unf <= nu;
    end else begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_loadable_counter_param.sv
// tb_loadable_counter_param: directed and random checks against a modular-arithmetic reference model
module tb_loadable_counter_param;
  localparam int W = 8;
  localparam int RV = 5;
  logic clk = 1'b0;
  logic rst, ld, en, updown, sat;
  logic [W-1:0] d, step, lim, q;
  logic ovf, unf;
  int errs = 0, checks = 0;
  int mq;
  bit mo, mu;

  loadable_counter_param #(.WIDTH(W), .RST_VAL(W'(RV))) dut (
    .clk(clk), .rst(rst), .ld(ld), .d(d), .en(en), .updown(updown),
    .step(step), .lim(lim), .sat(sat), .q(q), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit l_, input int d_, input bit e_, input bit u_,
                       input int st_, input int li_, input bit sa_);
    ld = l_; d = W'(d_); en = e_; updown = u_; step = W'(st_); lim = W'(li_); sat = sa_;
  endtask

  // Reference: counting is arithmetic modulo lim+1, with bounds for saturate
  task automatic tick(input string tag);
    int s, l, nq;
    bit no, nu;
    l = int'(lim);
    s = int'(step) > l ? l : int'(step);
    nq = mq;
    no = 0;
    nu = 0;
    if (rst) nq = RV;
    else if (ld) nq = int'(d) > l ? l : int'(d);
    else if (en && s != 0) begin
      if (updown) begin
        if (mq > l) begin nq = sat ? l : 0; no = 1; end
        else if (mq + s > l) begin nq = sat ? l : (mq + s) % (l + 1); no = 1; end
        else nq = mq + s;
      end else begin
        if (mq > l) nq = l;
        else if (s > mq) begin nq = sat ? 0 : (mq - s + l + 1) % (l + 1); nu = 1; end
        else nq = mq - s;
      end
    end
    mq = nq; mo = no; mu = nu;
    @(posedge clk);
    #1;
    chk({tag, ".q"}, 32'(q), 32'(mq));
    chk({tag, ".ovf"}, 32'(ovf), 32'(mo));
    chk({tag, ".unf"}, 32'(unf), 32'(mu));
  endtask

  initial begin
    rst = 1;
    drive(0, 0, 0, 1, 1, 15, 0);
    mq = 0;
    tick("reset");
    chk("reset_val", 32'(q), 32'(RV));
    rst = 0;
    // basic wrap up/down
    drive(1, 9, 0, 1, 1, 15, 0); tick("ld9");
    chk("ld9_const", 32'(q), 9);
    drive(0, 0, 1, 1, 1, 15, 0);
    for (int i = 0; i < 7; i++) tick("up15");
    chk("wrap15_q", 32'(q), 0);
    chk("wrap15_ovf", 32'(ovf), 1);
    updown = 0; tick("dn15");
    chk("unf15_q", 32'(q), 15);
    chk("unf15_unf", 32'(unf), 1);
    tick("dn15b");
    // modulus with step
    drive(1, 0, 0, 1, 3, 9, 0); tick("ld0");
    drive(0, 0, 1, 1, 3, 9, 0);
    for (int i = 0; i < 4; i++) tick("mod9");
    chk("mod9_q", 32'(q), 2);
    chk("mod9_ovf", 32'(ovf), 1);
    updown = 0; tick("mod9dn");
    chk("mod9dn_q", 32'(q), 9);
    chk("mod9dn_unf", 32'(unf), 1);
    tick("mod9dn2");
    // saturate
    drive(1, 10, 0, 1, 5, 12, 1); tick("ld10");
    drive(0, 0, 1, 1, 5, 12, 1);
    for (int i = 0; i < 3; i++) begin
      tick("sat12");
      chk("sat12_q", 32'(q), 12);
      chk("sat12_ovf", 32'(ovf), 1);
    end
    drive(1, 3, 0, 0, 5, 12, 1); tick("ld3");
    drive(0, 0, 1, 0, 5, 12, 1); tick("sat0");
    chk("sat0_q", 32'(q), 0);
    chk("sat0_unf", 32'(unf), 1);
    // clamping and out-of-range
    drive(1, 13, 0, 1, 1, 7, 0); tick("ldclamp");
    chk("ldclamp_q", 32'(q), 7);
    drive(1, 0, 0, 1, 11, 7, 0); tick("ld0b");
    drive(0, 0, 1, 1, 11, 7, 0); tick("stepclamp1");
    chk("stepclamp1_q", 32'(q), 7);
    tick("stepclamp2");
    chk("stepclamp2_q", 32'(q), 6);
    chk("stepclamp2_ovf", 32'(ovf), 1);
    drive(0, 0, 1, 1, 1, 4, 0); tick("oor_up");
    chk("oor_up_q", 32'(q), 0);
    chk("oor_up_ovf", 32'(ovf), 1);
    drive(1, 6, 0, 1, 1, 7, 0); tick("ld6");
    drive(0, 0, 1, 0, 1, 4, 0); tick("oor_dn");
    chk("oor_dn_q", 32'(q), 4);
    chk("oor_dn_unf", 32'(unf), 0);
    // priority and reset
    drive(1, 3, 1, 1, 1, 7, 0); tick("ld_en");
    chk("ld_en_q", 32'(q), 3);
    drive(1, 7, 0, 1, 1, 7, 0); tick("ld7");
    drive(0, 0, 1, 1, 1, 7, 0); rst = 1; tick("rst_ovf");
    chk("rst_ovf_q", 32'(q), 32'(RV));
    chk("rst_ovf_ovf", 32'(ovf), 0);
    rst = 0;
    en = 0;
    for (int i = 0; i < 10; i++) tick("hold");
    chk("hold_q", 32'(q), 32'(RV));
    // full range
    drive(1, 255, 0, 1, 1, 255, 0); tick("ld255");
    drive(0, 0, 1, 1, 1, 255, 0); tick("full");
    chk("full_q", 32'(q), 0);
    chk("full_ovf", 32'(ovf), 1);
    step = 0; tick("step0");
    chk("step0_q", 32'(q), 0);
    // random
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 5) != 0);
      updown = 1'($urandom);
      sat = 1'($urandom);
      d = W'($urandom);
      case ($urandom_range(0, 5))
        0: lim = 8'd255;
        1: lim = 8'd0;
        default: lim = W'($urandom_range(1, 40));
      endcase
      step = ($urandom_range(0, 4) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      tick("rand");
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/loadable_counter_param.md
# loadable_counter_param

Parametrised synchronous up/down counter with parallel load, runtime modulus limit, runtime step size, and selectable wrap or saturate behaviour. It is the general-purpose successor to the fixed 4-bit loadable up/down counter. It sits wherever the design needs a programmable tick or position counter, such as timers, address generators, and divide-by-N dividers. It reports overflow and underflow as registered one-cycle pulses.

## Interface
- WIDTH, 8: counter width in bits (≥ 2).
- RST_VAL, 0: value of q after reset; must be ≤ 2^WIDTH−1.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous and active-high.
- ld  input  1  parallel load of d.
- d  input  WIDTH  load value.
- en  input  1  count enable.
- updown  input  1  direction: 1 counts up, 0 counts down.
- step  input  WIDTH  increment or decrement per count event.
- lim  input  WIDTH  modulus limit; q ranges over 0..lim.
- sat  input  1  0 selects wrap mode, 1 selects saturate mode.
- q  output  WIDTH  counter value (registered).
- ovf  output  1  overflow pulse (registered).
- unf  output  1  underflow pulse (registered).

## Operation
- Priority at each rising clk edge is rst, then ld, then en, then hold.
- rst=1: q=RST_VAL, ovf=0, unf=0.
- ld=1: q=min(d, lim). en, updown and step are ignored. ovf=0, unf=0.
- en=0 without ld: q holds, ovf=0, unf=0.
- Count event (en=1, ld=0). Let s = min(step, lim); step > lim is clamped. step=0 (s=0) holds q with no flags.
- Arithmetic is done in WIDTH+1 bits, so no intermediate truncation occurs.
- Up, q ≤ lim: sum = q + s.
  - sum ≤ lim: q = sum, no flag.
  - sum > lim, wrap mode: q = sum − lim − 1, ovf=1.
  - sum > lim, saturate mode: q = lim, ovf=1.
- Down, q ≤ lim:
  - s ≤ q: q = q − s, no flag.
  - s > q, wrap mode: q = q + lim + 1 − s, unf=1.
  - s > q, saturate mode: q = 0, unf=1.
- Out-of-range case (q > lim, e.g. lim lowered at runtime or RST_VAL > lim):
  - Up: q = 0 in wrap mode or lim in saturate mode, ovf=1.
  - Down: q = lim, no flag.
- Saturate mode keeps pulsing ovf (or unf) on every count event that attempts to pass lim (or 0), including while q already sits at that bound.
- Full-range case: lim = 2^WIDTH−1 gives plain modulo-2^WIDTH counting. lim+1 must not be truncated.
- lim = 0: q stays 0. Every count event with s=0 holds with no flag.
- updown, step, lim and sat may change on any cycle. Each takes effect on the next edge; there is no internal state beyond q, ovf and unf.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on q, ovf and unf after edge N.
- ovf and unf are never both 1. Each is high for exactly the cycle following the event edge, aligned with the post-wrap or post-saturation q.
- ld and en asserted together: the load wins and no flag is raised.
- rst asserted mid-count: it overrides on that edge and clears any pulse that would have fired.
- q is never combinationally dependent on inputs.

## Test plan
- WIDTH=4, lim=15, step=1, sat=0. Reset, then ld=1 with d=9 for one cycle, then en=1 and updown=1.
  - Required: q = 9, 10, …, 15, 0.
  - ovf=1 only in the cycle q=0 appears. After updown=0, q counts down and unf pulses at the 0→15 transition.
- Modulus with step: lim=9, step=3, up, wrap, load 0.
  - Required: q = 0, 3, 6, 9, 2 (ovf pulse with q=2), 5.
  - Switch to down from 2: q = 9 (unf pulse), 6.
- Saturate mode: lim=12, step=5, sat=1, load 10, count up.
  - Required: q = 12 with ovf=1, and q stays 12 with ovf=1 on each further count event.
  - Count down from 3: q = 0 with unf=1.
- Clamping: lim=7.
  - ld with d=13 gives q=7.
  - step=11 behaves as step=7: from 0 counting up, q=7, then q=6 with ovf.
  - Lower lim to 4 while q=6, count up: q=0 with ovf. Same case counting down: q=4 with no flag.
- Priority and reset:
  - ld=1 and en=1 together load d, with ovf=unf=0.
  - Assert rst on the same edge that would overflow: q=RST_VAL and ovf stays 0.
  - en=0 holds q for 10 cycles with no flags.
- Full-range edge case: WIDTH=8, lim=255, step=1, q=255, count up.
  - Required: q=0 with ovf.
  - step=0 with en=1 holds q with no flag.
